// File: rtl/core_bus_xbar.sv
// ---------------------------------------------------------------------------
// core_bus_xbar
//
// Two-master crossbar that connects the instruction-fetch master (m0) and the
// LSU master (m1) to NUM_SLV address-mapped slave ports. Unmapped addresses go
// to an internal default slave.
//
// Each master may have at most one read outstanding. A slave counts as busy
// from the cycle a read is accepted until its s_rvld. When both masters want
// the same free slave in the same cycle, the grant alternates. The arbiter
// remembers the last conflict winner, and the first conflict after reset goes
// to m1. Requests reach the slave in the cycle they are accepted. Read data
// comes back to the owning master combinationally, in the s_rvld cycle.
//
// Optional feature macro: CORE_BUS_ERR_RESP_EN
//   defined   : an unmapped read returns 32'hDEAD_BEEF with m*_err=1 in the
//               rvld cycle. An unmapped write pulses m*_err the cycle after
//               it is accepted.
//   undefined : m*_err is tied to 0 and an unmapped read returns 0.
//
// Ports
//   CLK, RSTN               clock, synchronous active-low reset
//   m{0,1}_en/wen/addr/wdata   master request (wen == 0 means read)
//   m{0,1}_ready            request accepted this cycle
//   m{0,1}_rdata/rvld/err   master response
//   s_en/s_wen/s_addr/s_wdata  per-slave request lanes; s_addr is the offset
//                           from the region base
//   s_rdata/s_rvld          per-slave read response
// ---------------------------------------------------------------------------
module core_bus_xbar #(
    parameter int                        NUM_SLV  = 4,
    parameter int                        DATA_W   = 32,
    parameter int                        ADDR_W   = 32,
    parameter logic [NUM_SLV*ADDR_W-1:0] SLV_BASE = {32'hFFFF_3000, 32'hFFFF_2000,
                                                     32'hFFFF_1000, 32'hFFFF_0000},
    parameter logic [NUM_SLV*ADDR_W-1:0] SLV_LEN  = {4{32'h0000_1000}}
) (
    input  logic                          CLK,
    input  logic                          RSTN,

    input  logic                          m0_en,
    input  logic [DATA_W/8-1:0]           m0_wen,
    input  logic [ADDR_W-1:0]             m0_addr,
    input  logic [DATA_W-1:0]             m0_wdata,
    output logic                          m0_ready,
    output logic [DATA_W-1:0]             m0_rdata,
    output logic                          m0_rvld,
    output logic                          m0_err,

    input  logic                          m1_en,
    input  logic [DATA_W/8-1:0]           m1_wen,
    input  logic [ADDR_W-1:0]             m1_addr,
    input  logic [DATA_W-1:0]             m1_wdata,
    output logic                          m1_ready,
    output logic [DATA_W-1:0]             m1_rdata,
    output logic                          m1_rvld,
    output logic                          m1_err,

    output logic [NUM_SLV-1:0]            s_en,
    output logic [NUM_SLV*DATA_W/8-1:0]   s_wen,
    output logic [NUM_SLV*ADDR_W-1:0]     s_addr,
    output logic [NUM_SLV*DATA_W-1:0]     s_wdata,
    input  logic [NUM_SLV*DATA_W-1:0]     s_rdata,
    input  logic [NUM_SLV-1:0]            s_rvld
);

    localparam int            STRB    = DATA_W / 8;
    localparam int            TW      = $clog2(NUM_SLV + 1);
    // Target id NUM_SLV stands for the internal default slave.
    localparam logic [TW-1:0] DFLT_ID = TW'(NUM_SLV);

`ifdef CORE_BUS_ERR_RESP_EN
    localparam logic [DATA_W-1:0] DFLT_RDATA = DATA_W'(32'hDEAD_BEEF);
`else
    localparam logic [DATA_W-1:0] DFLT_RDATA = '0;
`endif

    // Region hit test written as an offset compare, so that base + len can
    // wrap past the top of the address space without overflowing. The loop
    // runs downward so that the lowest matching index wins.
    function automatic logic [TW-1:0] f_decode(input logic [ADDR_W-1:0] addr);
        logic [ADDR_W-1:0] base;
        logic [ADDR_W-1:0] len;
        f_decode = DFLT_ID;
        for (int i = NUM_SLV - 1; i >= 0; i--) begin
            base = SLV_BASE[i*ADDR_W +: ADDR_W];
            len  = SLV_LEN[i*ADDR_W +: ADDR_W];
            if ((addr >= base) && ((addr - base) < len)) begin
                f_decode = TW'(i);
            end
        end
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [NUM_SLV-1:0] r_busy;
    logic [NUM_SLV-1:0] r_owner;     // 0 = m0, 1 = m1; valid only while busy
    logic [1:0]         r_out;       // per-master read outstanding
    logic [1:0]         r_dflt_rd;   // default-slave read response due
`ifdef CORE_BUS_ERR_RESP_EN
    logic [1:0]         r_dflt_wr;   // default-slave write error pulse due
`endif
    logic               r_last_m1;   // last conflict winner was m1

    // ------------------------------------------------------------------
    // Decode and arbitration
    // ------------------------------------------------------------------
    logic [TW-1:0]      w_tgt0;
    logic [TW-1:0]      w_tgt1;
    logic               w_map0;
    logic               w_map1;
    logic               w_rd0;
    logic               w_rd1;
    logic [NUM_SLV-1:0] w_rsp;
    logic               w_rsp0;
    logic               w_rsp1;
    logic               w_tbusy0;
    logic               w_tbusy1;
    logic               w_elig0;
    logic               w_elig1;
    logic               w_conf;
    logic               w_acc0;
    logic               w_acc1;

    always_comb begin
        w_tgt0   = f_decode(m0_addr);
        w_tgt1   = f_decode(m1_addr);
        w_map0   = (w_tgt0 != DFLT_ID);
        w_map1   = (w_tgt1 != DFLT_ID);
        w_rd0    = (m0_wen == '0);
        w_rd1    = (m1_wen == '0);

        // While reset is asserted, state still shows pre-reset values, so
        // every response is masked.
        w_rsp    = s_rvld & r_busy & {NUM_SLV{RSTN}};
        w_rsp0   = RSTN && (r_dflt_rd[0] || (|(w_rsp & ~r_owner)));
        w_rsp1   = RSTN && (r_dflt_rd[1] || (|(w_rsp & r_owner)));

        // A slave that is returning its response this cycle is free again,
        // which allows back-to-back accepts.
        w_tbusy0 = 1'b0;
        w_tbusy1 = 1'b0;
        for (int i = 0; i < NUM_SLV; i++) begin
            if ((w_tgt0 == TW'(i)) && r_busy[i] && !s_rvld[i]) w_tbusy0 = 1'b1;
            if ((w_tgt1 == TW'(i)) && r_busy[i] && !s_rvld[i]) w_tbusy1 = 1'b1;
        end

        w_elig0  = RSTN && m0_en && !(r_out[0] && !w_rsp0) && !w_tbusy0;
        w_elig1  = RSTN && m1_en && !(r_out[1] && !w_rsp1) && !w_tbusy1;
        w_conf   = w_elig0 && w_elig1 && (w_tgt0 == w_tgt1);
        w_acc0   = w_elig0 && (!w_conf || r_last_m1);
        w_acc1   = w_elig1 && (!w_conf || !r_last_m1);
    end

    assign m0_ready = w_acc0;
    assign m1_ready = w_acc1;

    // ------------------------------------------------------------------
    // Request lanes. At most one master is accepted per slave per cycle.
    // ------------------------------------------------------------------
    always_comb begin
        s_en    = '0;
        s_wen   = '0;
        s_addr  = '0;
        s_wdata = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            if (w_acc0 && (w_tgt0 == TW'(i))) begin
                s_en[i]                    = 1'b1;
                s_wen[i*STRB +: STRB]      = m0_wen;
                s_addr[i*ADDR_W +: ADDR_W] = m0_addr - SLV_BASE[i*ADDR_W +: ADDR_W];
                s_wdata[i*DATA_W +: DATA_W] = m0_wdata;
            end else if (w_acc1 && (w_tgt1 == TW'(i))) begin
                s_en[i]                    = 1'b1;
                s_wen[i*STRB +: STRB]      = m1_wen;
                s_addr[i*ADDR_W +: ADDR_W] = m1_addr - SLV_BASE[i*ADDR_W +: ADDR_W];
                s_wdata[i*DATA_W +: DATA_W] = m1_wdata;
            end
        end
    end

    // ------------------------------------------------------------------
    // Response routing. rdata stays at 0 whenever rvld is low.
    // ------------------------------------------------------------------
    always_comb begin
        m0_rvld  = w_rsp0;
        m1_rvld  = w_rsp1;
        m0_rdata = '0;
        m1_rdata = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            if (w_rsp[i] && !r_owner[i]) m0_rdata = s_rdata[i*DATA_W +: DATA_W];
            if (w_rsp[i] &&  r_owner[i]) m1_rdata = s_rdata[i*DATA_W +: DATA_W];
        end
        if (RSTN && r_dflt_rd[0]) m0_rdata = DFLT_RDATA;
        if (RSTN && r_dflt_rd[1]) m1_rdata = DFLT_RDATA;
    end

`ifdef CORE_BUS_ERR_RESP_EN
    assign m0_err = RSTN && (r_dflt_rd[0] || r_dflt_wr[0]);
    assign m1_err = RSTN && (r_dflt_rd[1] || r_dflt_wr[1]);
`else
    assign m0_err = 1'b0;
    assign m1_err = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Sequential state
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            r_busy    <= '0;
            r_owner   <= '0;
            r_out     <= '0;
            r_dflt_rd <= '0;
`ifdef CORE_BUS_ERR_RESP_EN
            r_dflt_wr <= '0;
`endif
            r_last_m1 <= 1'b0;
        end else begin
            if (w_conf) r_last_m1 <= ~r_last_m1;

            // A new accept to a slave takes priority over the response that
            // frees it in the same cycle.
            for (int i = 0; i < NUM_SLV; i++) begin
                if (w_acc0 && w_rd0 && (w_tgt0 == TW'(i))) begin
                    r_busy[i]  <= 1'b1;
                    r_owner[i] <= 1'b0;
                end else if (w_acc1 && w_rd1 && (w_tgt1 == TW'(i))) begin
                    r_busy[i]  <= 1'b1;
                    r_owner[i] <= 1'b1;
                end else if (w_rsp[i]) begin
                    r_busy[i]  <= 1'b0;
                end
            end

            if (w_acc0 && w_rd0)  r_out[0] <= 1'b1;
            else if (w_rsp0)      r_out[0] <= 1'b0;
            if (w_acc1 && w_rd1)  r_out[1] <= 1'b1;
            else if (w_rsp1)      r_out[1] <= 1'b0;

            r_dflt_rd <= {w_acc1 && w_rd1 && !w_map1, w_acc0 && w_rd0 && !w_map0};
`ifdef CORE_BUS_ERR_RESP_EN
            r_dflt_wr <= {w_acc1 && !w_rd1 && !w_map1, w_acc0 && !w_rd0 && !w_map0};
`endif
        end
    end

endmodule

// File: tb/tb_core_bus_xbar.sv
// Testbench for core_bus_xbar with the default parameters. A directed
// prologue walks through the main routing, arbitration and reset cases. A
// randomized phase follows, in which a responder model plays the slaves.
// Every cycle, all DUT outputs are compared against a reference model of the
// routing rules.
module tb_core_bus_xbar;

    logic         CLK = 1'b0;
    logic         RSTN;
    logic         m0_en, m1_en;
    logic [3:0]   m0_wen, m1_wen;
    logic [31:0]  m0_addr, m1_addr, m0_wdata, m1_wdata;
    logic         m0_ready, m1_ready, m0_rvld, m1_rvld, m0_err, m1_err;
    logic [31:0]  m0_rdata, m1_rdata;
    logic [3:0]   s_en;
    logic [15:0]  s_wen;
    logic [127:0] s_addr, s_wdata, s_rdata;
    logic [3:0]   s_rvld;

    core_bus_xbar dut (
        .CLK(CLK), .RSTN(RSTN),
        .m0_en(m0_en), .m0_wen(m0_wen), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_ready(m0_ready), .m0_rdata(m0_rdata), .m0_rvld(m0_rvld), .m0_err(m0_err),
        .m1_en(m1_en), .m1_wen(m1_wen), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_ready(m1_ready), .m1_rdata(m1_rdata), .m1_rvld(m1_rvld), .m1_err(m1_err),
        .s_en(s_en), .s_wen(s_wen), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_rdata(s_rdata), .s_rvld(s_rvld)
    );

    always #5 CLK = ~CLK;

`ifdef CORE_BUS_ERR_RESP_EN
    localparam bit          ERR_EN = 1'b1;
    localparam logic [31:0] DFLT   = 32'hDEAD_BEEF;
`else
    localparam bit          ERR_EN = 1'b0;
    localparam logic [31:0] DFLT   = 32'h0;
`endif

    int n_chk = 0;
    int n_err = 0;

    // Stimulus for the next cycle. step() applies it at the falling edge.
    bit           st_rstn;
    bit           st_en   [2];
    logic [3:0]   st_wen  [2];
    logic [31:0]  st_addr [2];
    logic [31:0]  st_wdata[2];
    logic [3:0]   st_rvld;
    logic [127:0] st_rdata;

    // Reference model: which master owns each slave (-1 = free), outstanding
    // reads, pending default-slave replies and the next conflict winner.
    int mo_owner[4];
    bit mo_out[2];
    bit mo_dflt_rd[2];
    bit mo_dflt_wr[2];
    int mo_next_win;
    bit acc_rd[4];
    int resp_cnt[4];

    task automatic check_val(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic int tb_decode(input logic [31:0] a);
        longint av;
        longint base;
        av = longint'({32'h0, a});
        for (int i = 0; i < 4; i++) begin
            base = 64'hFFFF_0000 + longint'(i) * 4096;
            if (av >= base && av < base + 4096) return i;
        end
        return 4;
    endfunction

    function automatic logic [31:0] rand_addr();
        int          k;
        logic [31:0] base;
        k    = $urandom_range(0, 9);
        base = 32'hFFFF_0000 + 32'($urandom_range(0, 3)) * 32'h1000;
        if (k <= 5) return base + 32'($urandom_range(0, 1023)) * 4;
        if (k == 6) return base + 32'hFFC;
        if (k == 7) return 32'hFFFF_4000;
        if (k == 8) return 32'hFFFE_FFFC;
        return $urandom;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            mo_owner[i] = -1;
            acc_rd[i]   = 1'b0;
        end
        for (int m = 0; m < 2; m++) begin
            mo_out[m]     = 1'b0;
            mo_dflt_rd[m] = 1'b0;
            mo_dflt_wr[m] = 1'b0;
        end
        mo_next_win = 1;
    endtask

    task automatic model_eval();
        bit           e_rdy[2], e_rvld[2], e_err[2], rd[2], elig[2], nd_rd[2], nd_wr[2];
        logic [31:0]  e_rdata[2];
        int           tgt[2];
        bit           freed[4];
        int           w;
        int           o;
        logic [3:0]   e_sen;
        logic [15:0]  e_wen;
        logic [127:0] e_addr, e_wdata;
        e_sen   = '0;
        e_wen   = '0;
        e_addr  = '0;
        e_wdata = '0;
        for (int m = 0; m < 2; m++) begin
            e_rdy[m] = 0; e_rvld[m] = 0; e_err[m] = 0; e_rdata[m] = '0;
            nd_rd[m] = 0; nd_wr[m] = 0; elig[m] = 0;
            tgt[m] = tb_decode(st_addr[m]);
            rd[m]  = (st_wen[m] == 4'h0);
        end
        for (int i = 0; i < 4; i++) freed[i] = 0;

        if (st_rstn) begin
            for (int i = 0; i < 4; i++) begin
                if (st_rvld[i] && mo_owner[i] >= 0) begin
                    o = mo_owner[i];
                    freed[i]   = 1;
                    e_rvld[o]  = 1;
                    e_rdata[o] = st_rdata[i*32 +: 32];
                end
            end
            for (int m = 0; m < 2; m++) begin
                if (mo_dflt_rd[m]) begin
                    e_rvld[m]  = 1;
                    e_rdata[m] = DFLT;
                    e_err[m]   = ERR_EN;
                end
                if (mo_dflt_wr[m]) e_err[m] = ERR_EN;
                elig[m] = st_en[m] && !(mo_out[m] && !e_rvld[m]);
                if (tgt[m] < 4) begin
                    if (mo_owner[tgt[m]] >= 0 && !st_rvld[tgt[m]]) elig[m] = 0;
                end
            end
            if (elig[0] && elig[1] && tgt[0] == tgt[1]) begin
                w = mo_next_win;
                e_rdy[w] = 1;
                mo_next_win = 1 - w;
            end else begin
                e_rdy[0] = elig[0];
                e_rdy[1] = elig[1];
            end
            for (int m = 0; m < 2; m++) begin
                if (e_rdy[m] && tgt[m] < 4) begin
                    e_sen[tgt[m]]            = 1'b1;
                    e_wen[tgt[m]*4 +: 4]     = st_wen[m];
                    e_addr[tgt[m]*32 +: 32]  = st_addr[m] - (32'hFFFF_0000 + 32'(tgt[m]) * 32'h1000);
                    e_wdata[tgt[m]*32 +: 32] = st_wdata[m];
                end
            end
        end

        check_val("m0_ready", m0_ready, e_rdy[0]);
        check_val("m1_ready", m1_ready, e_rdy[1]);
        check_val("m0_rvld",  m0_rvld,  e_rvld[0]);
        check_val("m1_rvld",  m1_rvld,  e_rvld[1]);
        check_val("m0_rdata", m0_rdata, e_rdata[0]);
        check_val("m1_rdata", m1_rdata, e_rdata[1]);
        check_val("m0_err",   m0_err,   e_err[0]);
        check_val("m1_err",   m1_err,   e_err[1]);
        check_val("s_en",     s_en,     e_sen);
        check_val("s_wen",    s_wen,    e_wen);
        check_val("s_addr",   s_addr,   e_addr);
        check_val("s_wdata",  s_wdata,  e_wdata);

        if (!st_rstn) begin
            model_reset();
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (freed[i]) mo_owner[i] = -1;
                acc_rd[i] = 1'b0;
            end
            for (int m = 0; m < 2; m++) begin
                if (e_rvld[m]) mo_out[m] = 1'b0;
                if (e_rdy[m]) begin
                    if (rd[m]) begin
                        mo_out[m] = 1'b1;
                        if (tgt[m] < 4) begin
                            mo_owner[tgt[m]] = m;
                            acc_rd[tgt[m]]   = 1'b1;
                        end else begin
                            nd_rd[m] = 1'b1;
                        end
                    end else if (tgt[m] == 4) begin
                        nd_wr[m] = 1'b1;
                    end
                end
                mo_dflt_rd[m] = nd_rd[m];
                mo_dflt_wr[m] = nd_wr[m];
            end
        end
    endtask

    task automatic step();
        @(negedge CLK);
        RSTN     = st_rstn;
        m0_en    = st_en[0];    m1_en    = st_en[1];
        m0_wen   = st_wen[0];   m1_wen   = st_wen[1];
        m0_addr  = st_addr[0];  m1_addr  = st_addr[1];
        m0_wdata = st_wdata[0]; m1_wdata = st_wdata[1];
        s_rvld   = st_rvld;
        s_rdata  = st_rdata;
        #1;
        model_eval();
    endtask

    task automatic idle();
        st_rstn  = 1'b1;
        st_rvld  = '0;
        st_rdata = '0;
        for (int m = 0; m < 2; m++) begin
            st_en[m] = 0; st_wen[m] = '0; st_addr[m] = '0; st_wdata[m] = '0;
        end
    endtask

    task automatic rd_req(input int m, input logic [31:0] a);
        st_en[m]   = 1'b1;
        st_wen[m]  = 4'h0;
        st_addr[m] = a;
    endtask

    initial begin
        RSTN = 0; m0_en = 0; m1_en = 0; m0_wen = 0; m1_wen = 0;
        m0_addr = 0; m1_addr = 0; m0_wdata = 0; m1_wdata = 0;
        s_rvld = 0; s_rdata = 0;
        model_reset();
        idle();

        st_rstn = 0; step(); step();

        // Single read from m0 to slave 0, with the response two cycles later.
        idle(); rd_req(0, 32'hFFFF_0010); step();
        check_val("tp1_ready", m0_ready, 1);
        check_val("tp1_sen", s_en, 4'b0001);
        check_val("tp1_off", s_addr[31:0], 32'h10);
        idle(); step();
        idle(); st_rvld = 4'b0001; st_rdata[31:0] = 32'h1234_5678; step();
        check_val("tp1_rvld", m0_rvld, 1);
        check_val("tp1_rdata", m0_rdata, 32'h1234_5678);

        // Conflict on slave 1: m1 wins first, m0 takes the slave back-to-back.
        idle(); rd_req(0, 32'hFFFF_1000); rd_req(1, 32'hFFFF_1004); step();
        check_val("tp2_m1_rdy", m1_ready, 1);
        check_val("tp2_m0_rdy", m0_ready, 0);
        idle(); rd_req(0, 32'hFFFF_1000); step();
        check_val("tp2_busy", m0_ready, 0);
        idle(); rd_req(0, 32'hFFFF_1000); st_rvld = 4'b0010; st_rdata[63:32] = 32'hCAFE_0001; step();
        check_val("tp2_b2b", m0_ready, 1);
        check_val("tp2_m1_rvld", m1_rvld, 1);
        check_val("tp2_m1_rdata", m1_rdata, 32'hCAFE_0001);
        idle(); st_rvld = 4'b0010; st_rdata[63:32] = 32'hCAFE_0002; step();
        check_val("tp2_m0_rvld", m0_rvld, 1);
        idle(); rd_req(0, 32'hFFFF_1000); rd_req(1, 32'hFFFF_1004); step();
        check_val("tp2_next_m0", m0_ready, 1);
        check_val("tp2_next_m1", m1_ready, 0);
        idle(); st_rvld = 4'b0010; step();

        // Parallel accepts to different slaves.
        idle(); rd_req(0, 32'hFFFF_0020);
        st_en[1] = 1; st_wen[1] = 4'b0001; st_addr[1] = 32'hFFFF_2008; st_wdata[1] = 32'hAA; step();
        check_val("tp3_rdy0", m0_ready, 1);
        check_val("tp3_rdy1", m1_ready, 1);
        check_val("tp3_sen", s_en, 4'b0101);
        check_val("tp3_off", s_addr[95:64], 32'h8);
        check_val("tp3_wen", s_wen[11:8], 4'b0001);
        check_val("tp3_wdata", s_wdata[95:64], 32'hAA);
        idle(); st_rvld = 4'b0001; step();

        // Unmapped read through the default slave.
        idle(); rd_req(1, 32'h0000_0100); step();
        check_val("tp4_ready", m1_ready, 1);
        check_val("tp4_sen", s_en, 4'b0000);
        idle(); step();
        check_val("tp4_rvld", m1_rvld, 1);
        check_val("tp4_rdata", m1_rdata, DFLT);
        check_val("tp4_err", m1_err, ERR_EN);

        // One outstanding read per master, and a spurious response.
        idle(); rd_req(0, 32'hFFFF_3000); step();
        idle(); rd_req(0, 32'hFFFF_0000); st_rvld = 4'b0100; st_rdata = {4{32'h5555_AAAA}}; step();
        check_val("tp5_block", m0_ready, 0);
        check_val("tp5_spur0", m0_rvld, 0);
        check_val("tp5_spur1", m1_rvld, 0);
        idle(); rd_req(0, 32'hFFFF_0000); st_rvld = 4'b1000; st_rdata[127:96] = 32'h0BAD_F00D; step();
        check_val("tp5_rvld", m0_rvld, 1);
        check_val("tp5_reissue", m0_ready, 1);
        idle(); st_rvld = 4'b0001; step();

        // Reset with a read pending; the late response is ignored.
        idle(); rd_req(1, 32'hFFFF_1000); step();
        idle(); st_rstn = 0; step();
        idle(); st_rvld = 4'b0010; rd_req(0, 32'hFFFF_1000); step();
        check_val("tp6_ready", m0_ready, 1);
        check_val("tp6_late1", m1_rvld, 0);
        check_val("tp6_late0", m0_rvld, 0);
        idle(); st_rvld = 4'b0010; step();
        check_val("tp6_rvld", m0_rvld, 1);

        idle(); st_rstn = 0; step(); step();
        for (int i = 0; i < 4; i++) resp_cnt[i] = 0;

        for (int cyc = 0; cyc < 4000; cyc++) begin
            idle();
            st_rstn  = ($urandom_range(0, 299) != 0);
            st_rdata = {$urandom, $urandom, $urandom, $urandom};
            for (int i = 0; i < 4; i++) begin
                if (resp_cnt[i] == 1) begin
                    st_rvld[i]  = 1'b1;
                    resp_cnt[i] = 0;
                end else if (resp_cnt[i] > 1) begin
                    resp_cnt[i]--;
                end else if ($urandom_range(0, 15) == 0) begin
                    st_rvld[i] = 1'b1;
                end
            end
            for (int m = 0; m < 2; m++) begin
                st_en[m]    = ($urandom_range(0, 9) < 7);
                st_wen[m]   = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
                st_addr[m]  = rand_addr();
                st_wdata[m] = $urandom;
            end
            step();
            for (int i = 0; i < 4; i++) begin
                if (acc_rd[i]) resp_cnt[i] = $urandom_range(1, 4);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
